timer_apb_arbiter: RTL and testbench
====================================

# timer_apb_arbiter

Round-robin arbiter that lets NUM_REQ independent requesters share the single APB slave port of the timer peripheral. Examples are the core's bus bridge, a DMA engine and a debug port. Each requester issues single transfers over a simple req/ack interface. The block serialises them into legal two-phase APB transfers (SETUP then ACCESS) and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2 to 8)
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width

Ports:
- HCLK  in  1  system clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-requester transfer request, level
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed, same layout
- ack  out  NUM_REQ  one-hot, one-cycle transfer-complete pulse
- rdata  out  DATA_W  read data, valid while any ack bit is high
- grant_idx  out  $clog2(NUM_REQ)  index of the owner of the current or last transfer
- busy  out  1  high in SETUP, ACCESS and DONE
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any req bit is high, select the winner with round-robin arbitration.
  - Search begins at index (last_grant+1) mod NUM_REQ.
  - Register the winner's write, addr and wdata into PWRITE/PADDR/PWDATA.
  - Register the winner's index into grant_idx, then go to SETUP.
  - If no req bit is high, stay in IDLE.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. There is no PREADY, so ACCESS always lasts exactly one cycle. Capture PRDATA into the rdata register at the end of ACCESS for reads; writes leave rdata unchanged. Go to DONE.
- DONE: PSEL=0, PENABLE=0. ack[grant_idx]=1 and rdata is valid. Set last_grant=grant_idx. Go to IDLE.
- Requester contract:
  - Hold req, req_write, req_addr and req_wdata stable from assertion until ack is seen.
  - Deassert req on the edge that ends the ack cycle, or keep it high to request another transfer.
  - A held req is re-arbitrated fairly against the other requesters in the next IDLE.
- Arbiter inputs are sampled only in IDLE. Changes to req or its fields during SETUP, ACCESS or DONE are ignored, and the in-flight transfer completes with its latched values.
- A req dropped mid-transfer (protocol violation) still completes and still produces ack.
- PADDR, PWRITE and PWDATA hold their last values outside a transfer. No address decoding is done; the address passes through unmodified.

## Timing
- Reset values (asynchronous, immediate on RST=1):
  - state=IDLE.
  - PSEL, PENABLE, PWRITE, ack and busy are 0.
  - PADDR, PWDATA, rdata and grant_idx are 0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- Latency: req high at edge k (state IDLE) gives SETUP in cycle k+1, ACCESS in k+2 and ack in k+3.
- Transfer slot is 4 cycles (IDLE, SETUP, ACCESS, DONE). Sustained throughput is one transfer per 4 cycles.
- Fairness: with all NUM_REQ requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0… Worst-case wait is NUM_REQ*4 cycles.
- ack is never high for more than one cycle per transfer, and never for more than one requester.
- Reset mid-transfer (any state): APB signals drop the same cycle and no ack is issued. The requester must re-issue after reset.
- RST deassertion: the first arbitration happens at the first HCLK edge after RST is low.

## Test plan
- Single write: req[0] with write=1, addr=0x8001000C, wdata=0x80 at edge k.
  - Required: SETUP in k+1 with PSEL=1, PENABLE=0, PADDR=0x8001000C, PWDATA=0x80.
  - Required: ACCESS in k+2 with PENABLE=1.
  - Required: ack=2'b01 in k+3.
  - Timer's TSCR subsequently reads 0x80.
- Single read: req[1] reads 0x80010008 (TCNT) with a timer enabled.
  - Required: ack=2'b10 in k+3.
  - Required: rdata equals PRDATA sampled during ACCESS, and grant_idx=1.
- Simultaneous: req=2'b11 held continuously from reset.
  - Required: ack order is 0,1,0,1 with spacing of 4 cycles.
  - Required: PADDR alternates between the two requesters' addresses.
- Late arrival: req[0] held continuously; req[1] rises during a requester-0 ACCESS.
  - Required: the next granted transfer is requester 1, followed by requester 0.
- Mid-transfer change: requester 0 changes req_addr from 0x80010014 to 0x80010018 during SETUP.
  - Required: PADDR stays 0x80010014 through ACCESS, and ack still fires.
- Reset in ACCESS: RST pulsed high during a req[0] ACCESS cycle.
  - Required: PSEL, PENABLE, ack and busy are 0 immediately.
  - Required: no ack for that transfer.
  - Required: after RST falls, with req=2'b11, requester 0 is granted first.

Source files
------------

// File: rtl/timer_apb_arbiter.sv
// Round-robin arbiter that serialises single req/ack transfers from NUM_REQ
// requesters into two-phase APB transfers on the timer's slave port.
module timer_apb_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      HCLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [IDX_W-1:0]  grant_q,  grant_d;
  logic [IDX_W-1:0]  last_q,   last_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q,  paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin search: walking offsets from farthest to nearest lets the
  // nearest requester after last_q overwrite any earlier candidate.
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it holding a value and no latch is inferred.
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand     = (int'(last_q) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d  = ST_SETUP;
          grant_d  = win_idx;
          pwrite_d = req_write[win_idx];
          paddr_d  = addr_arr[win_idx];
          pwdata_d = wdata_arr[win_idx];
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (!pwrite_q) rdata_d = PRDATA;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge RST) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Controls decode straight from state so reset silences the bus at once.
  assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign busy      = (state_q != ST_IDLE);
  assign ack       = (state_q == ST_DONE) ? (NUM_REQ'(1) << grant_q) : '0;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rdata     = rdata_q;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_timer_apb_arbiter.sv
// Scoreboard bench for timer_apb_arbiter: directed transfers against a small
// timer register model, with a monitor popping expectations on every ack.
module tb_timer_apb_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             HCLK = 1'b0;
  logic             RST;
  logic [NR-1:0]    req, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    rdata;
  logic [0:0]       grant_idx;
  logic             busy, PSEL, PENABLE, PWRITE;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA, PRDATA;

  timer_apb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK(HCLK), .RST(RST), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .grant_idx(grant_idx), .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 HCLK = ~HCLK;

  // Timer register model: regs[PADDR[4:2]], TCNT at 0x08 counts while TSCR[7].
  logic [31:0] regs [8];
  logic [31:0] tcnt;
  int          cyc = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(posedge HCLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) regs[i] <= 32'h1000_0000 + 32'(i);
      tcnt <= '0;
    end else begin
      if (PSEL && PENABLE && PWRITE) regs[PADDR[4:2]] <= PWDATA;
      if (regs[3][7]) tcnt <= tcnt + 1;
    end
  end

  always_comb begin
    PRDATA = 32'hBAD0_BAD0;
    if (PSEL && PENABLE) PRDATA = (PADDR[4:2] == 3'd2) ? tcnt : regs[PADDR[4:2]];
  end

  typedef struct {
    logic [NR-1:0] ack;
    logic [0:0]    idx;
    bit            chk;
    logic [31:0]   rd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input bit chk, input logic [31:0] rd);
    exp_t e;
    e.ack = NR'(1 << i);
    e.idx = 1'(i);
    e.chk = chk;
    e.rd  = rd;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    req[i]               = r;
    req_write[i]         = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_ack(input string name, input int bound);
    int n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (ack == '0 && n < bound);
    check(name, 64'(ack != '0), 1);
  endtask

  task automatic wait_setup(input string name, input int bound);
    int n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!(PSEL && !PENABLE) && n < bound);
    check(name, 64'(PSEL && !PENABLE), 1);
  endtask

  // One isolated transfer, starting at a negedge while the arbiter is idle.
  task automatic do_single(input int i, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input bit chk, input logic [31:0] rd);
    set_req(i, 1'b1, w, a, d);
    push(i, chk, rd);
    @(negedge HCLK);
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, a);
    check("setup_pwrite", PWRITE, w);
    if (w) check("setup_pwdata", PWDATA, d);
    check("setup_grant", grant_idx, i);
    check("setup_busy", busy, 1);
    @(negedge HCLK);
    check("access_psel", PSEL, 1);
    check("access_penable", PENABLE, 1);
    @(negedge HCLK);
    check("ack_latency", ack, 1 << i);
    check("done_psel", PSEL, 0);
    req[i] = 1'b0;
    @(negedge HCLK);
    check("idle_busy", busy, 0);
  endtask

  // Monitor: every ack pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (ack != '0) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got ack=%b grant=%0d, expected no ack", ack, grant_idx);
        end else begin
          e = sb.pop_front();
          check("sb_ack", ack, e.ack);
          check("sb_grant", grant_idx, e.idx);
          if (e.chk) check("sb_rdata", rdata, e.rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int last_cyc;
    RST = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge HCLK);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rdata", rdata, 0);
    check("rst_grant", grant_idx, 0);
    RST = 1'b0;

    // Single write to TSCR enables the timer, then read it back.
    do_single(0, 1'b1, 32'h8001_000C, 32'h80, 1'b0, 32'h0);
    do_single(0, 1'b0, 32'h8001_000C, 32'h0, 1'b1, 32'h80);
    // TCNT read: value seen during ACCESS is two edges after issue.
    do_single(1, 1'b0, 32'h8001_0008, 32'h0, 1'b1, tcnt + 2);

    // Late arrival: req[1] rises during requester-0 ACCESS.
    set_req(0, 1'b1, 1'b1, 32'h8001_0010, 32'h55);
    push(0, 1'b0, 32'h0);
    @(negedge HCLK);
    @(negedge HCLK);
    check("late_access", PENABLE, 1);
    set_req(1, 1'b1, 1'b0, 32'h8001_0010, 32'h0);
    push(1, 1'b1, 32'h55);
    push(0, 1'b0, 32'h0);
    wait_ack("late_ack0", 4);
    wait_ack("late_ack1", 8);
    check("late_second_grant", grant_idx, 1);
    wait_ack("late_ack2", 8);
    check("late_third_grant", grant_idx, 0);
    req = '0;
    @(negedge HCLK);

    // Address changes in SETUP and req drops in ACCESS: latched transfer completes.
    set_req(0, 1'b1, 1'b0, 32'h8001_0014, 32'h0);
    push(0, 1'b1, 32'h1000_0005);
    @(negedge HCLK);
    check("mid_setup_paddr", PADDR, 32'h8001_0014);
    set_req(0, 1'b1, 1'b0, 32'h8001_0018, 32'h0);
    @(negedge HCLK);
    check("mid_access_paddr", PADDR, 32'h8001_0014);
    check("mid_access_penable", PENABLE, 1);
    req[0] = 1'b0;
    wait_ack("mid_ack_seen", 4);
    check("mid_ack", ack, 2'b01);
    @(negedge HCLK);
    check("mid_idle_busy", busy, 0);

    // Reset during ACCESS, then both requesters held: strict 0,1,0,1 rotation.
    set_req(0, 1'b1, 1'b1, 32'h8001_0000, 32'hFF);
    @(negedge HCLK);
    @(negedge HCLK);
    check("rst_mid_access", PENABLE, 1);
    RST = 1'b1;
    #1;
    check("rst_mid_psel", PSEL, 0);
    check("rst_mid_penable", PENABLE, 0);
    check("rst_mid_ack", ack, 0);
    check("rst_mid_busy", busy, 0);
    set_req(0, 1'b1, 1'b0, 32'h8001_0000, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h8001_0004, 32'h0);
    for (int k = 0; k < 2; k++) begin
      push(0, 1'b1, 32'h1000_0000);
      push(1, 1'b1, 32'h1000_0001);
    end
    @(negedge HCLK);
    check("rst_hold_ack", ack, 0);
    check("rst_hold_busy", busy, 0);
    RST = 1'b0;
    last_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_setup("rr_setup_seen", 8);
      check("rr_paddr", PADDR, (i % 2 == 1) ? 32'h8001_0004 : 32'h8001_0000);
      wait_ack("rr_ack_seen", 4);
      if (i > 0) check("rr_spacing", cyc - last_cyc, 4);
      last_cyc = cyc;
    end
    req = '0;
    repeat (6) @(negedge HCLK);
    check("idle_no_activity", busy, 0);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
